// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory, PC sequencer and a
// one-entry registered output buffer with valid/ready toward the decode stage.
module instr_fetch_unit #(
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int INSTR_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [1:0]         alu_op,
    output logic [1:0]         write_reg,
    output logic [1:0]         read_reg1,
    output logic [1:0]         read_reg2,
    output logic               reg_write,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [INSTR_W-1:0] mem_r [IMEM_DEPTH];
    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W:0]    count_r;
    logic [ADDR_W:0]    len_r;
    logic [ADDR_W:0]    len_clamp_s;
    logic [INSTR_W-1:0] fields_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               fetch_s;
    logic               launch_s;
    logic               load_go_s;

    // Next-state, fetch-fire and launch decisions
    always_comb begin
        state_nxt_s = state_r;
        fetch_s     = 1'b0;
        launch_s    = 1'b0;
        load_go_s   = load_en && (state_r == ST_IDLE);
        if (prog_len > DEPTH_C) begin
            len_clamp_s = DEPTH_C;
        end else begin
            len_clamp_s = prog_len;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_clamp_s == {(ADDR_W+1){1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                        launch_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if ((!valid_r || instr_ready) && (count_r < len_r)) begin
                    fetch_s = 1'b1;
                    if ((count_r + ONE_C) == len_r) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (valid_r && instr_ready) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Instruction memory write port; contents survive reset
    always_ff @(posedge clk) begin
        if (load_go_s) begin
            mem_r[load_addr] <= load_data;
        end
    end

    // Sequencer, PC/count and registered output buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            pc_r     <= {ADDR_W{1'b0}};
            count_r  <= {(ADDR_W+1){1'b0}};
            len_r    <= {(ADDR_W+1){1'b0}};
            fields_r <= {INSTR_W{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
            if (launch_s) begin
                pc_r    <= {ADDR_W{1'b0}};
                count_r <= {(ADDR_W+1){1'b0}};
                len_r   <= len_clamp_s;
            end else if (fetch_s) begin
                pc_r     <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                count_r  <= count_r + ONE_C;
                fields_r <= mem_r[pc_r];
            end
            // A handshake without a refill empties the buffer
            if (fetch_s) begin
                valid_r <= 1'b1;
            end else if (valid_r && instr_ready) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign instr_valid = valid_r;
    assign alu_op      = fields_r[7:6];
    assign write_reg   = fields_r[5:4];
    assign read_reg1   = fields_r[3:2];
    assign read_reg2   = fields_r[1:0];
    assign reg_write   = valid_r && instr_ready;
    assign pc          = pc_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected words are queued at launch
// and popped on every observed handshake.
module tb_instr_fetch_unit;

    logic       clk;
    logic       reset;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic [4:0] prog_len;
    logic       instr_ready;
    logic       instr_valid;
    logic [1:0] alu_op;
    logic [1:0] write_reg;
    logic [1:0] read_reg1;
    logic [1:0] read_reg2;
    logic       reg_write;
    logic [3:0] pc;
    logic       busy;
    logic       done;

    int         n_chk;
    int         n_fail;
    logic [7:0] model [16];
    logic [7:0] sb [$];

    instr_fetch_unit #(.IMEM_DEPTH(16), .ADDR_W(4), .INSTR_W(8)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .prog_len(prog_len),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .alu_op(alu_op),
        .write_reg(write_reg), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .reg_write(reg_write), .pc(pc), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
        model[a] = d;
    endtask

    // Cycle 0 is the cycle in which start is high; stall_lo<0 disables stalls.
    task automatic run_prog(input logic [4:0] len, input int exp_n, input int stall_lo,
                            input int stall_hi, input int inj_c, input int rst_c,
                            input int ncyc, input int exp_pc);
        int         hs;
        int         dn;
        int         last_hs;
        int         done_c;
        int         busy_seen;
        logic [7:0] cur;
        logic [7:0] prev;
        hs = 0; dn = 0; last_hs = -1; done_c = -1; busy_seen = 0; prev = 8'h00;
        for (int i = 0; i < exp_n; i++) sb.push_back(model[i % 16]);
        @(posedge clk); #1;
        start = 1'b1; prog_len = len; instr_ready = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cur = {alu_op, write_reg, read_reg1, read_reg2};
            if (c < 2) chk("early_valid", instr_valid, 0);
            if (stall_lo < 0 && c >= 2) chk("valid_seq", instr_valid, (c < 2 + exp_n) ? 1 : 0);
            if (c >= stall_lo && c <= stall_hi) begin
                chk("stall_valid", instr_valid, 1);
                chk("stall_rw", reg_write, 0);
                chk("stall_pc", pc, 2);
                if (c > stall_lo) chk("stall_hold", cur, prev);
            end
            if (instr_valid && instr_ready) begin
                chk("rw_hs", reg_write, 1);
                if (sb.size() == 0) begin
                    chk("sb_extra", hs, exp_n);
                end else begin
                    chk("fields", cur, sb.pop_front());
                end
                hs++;
                last_hs = c;
            end else if (!instr_valid) begin
                chk("rw_idle", reg_write, 0);
            end
            if (done) begin dn++; done_c = c; end
            if (busy) busy_seen = 1;
            prev = cur;
            @(posedge clk); #1;
            start = 1'b0; load_en = 1'b0;
            instr_ready = !((c + 1) >= stall_lo && (c + 1) <= stall_hi);
            if (c + 1 == inj_c) begin
                load_en = 1'b1; load_addr = 4'd1; load_data = 8'hFF;
                start = 1'b1; prog_len = 5'd2;
            end
            if (c + 1 == rst_c) begin
                reset = 1'b0;
                #1;
                chk("rst_valid", instr_valid, 0);
                chk("rst_pc", pc, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                sb.delete();
                @(posedge clk); #1;
                chk("rst_hold_done", done, 0);
                chk("rst_hold_valid", instr_valid, 0);
                reset = 1'b1;
                return;
            end
        end
        chk("hs_count", hs, exp_n);
        chk("done_count", dn, 1);
        if (exp_n > 0) begin
            chk("done_cycle", done_c, last_hs + 1);
        end else begin
            chk("done_cycle", done_c, 1);
            chk("busy_len0", busy_seen, 0);
        end
        chk("sb_empty", sb.size(), 0);
        if (exp_pc >= 0) chk("end_pc", pc, exp_pc);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        reset = 1'b0; load_en = 1'b0; load_addr = 4'd0; load_data = 8'h00;
        start = 1'b0; prog_len = 5'd0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", instr_valid, 0);
        chk("reset_pc", pc, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fields", {alu_op, write_reg, read_reg1, read_reg2}, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        load_word(4'd0, 8'h1B);
        load_word(4'd1, 8'h64);
        load_word(4'd2, 8'hC0);
        for (int i = 3; i < 16; i++) load_word(4'(i), 8'(i * 37 + 5));

        run_prog(5'd3, 3, -1, -1, -1, -1, 8, 3);     // basic program
        run_prog(5'd3, 3, 3, 6, -1, -1, 12, 3);      // stall on 2nd instruction
        run_prog(5'd0, 0, -1, -1, -1, -1, 4, -1);    // empty program
        run_prog(5'd3, 3, -1, -1, 2, -1, 8, 3);      // load/start while busy
        run_prog(5'd3, 3, -1, -1, -1, -1, 8, 3);     // mem[1] must be intact
        run_prog(5'd20, 16, -1, -1, -1, -1, 21, 0);  // clamped length, pc wraps
        run_prog(5'd3, 3, -1, -1, -1, 4, 8, -1);     // reset after 2nd handshake
        run_prog(5'd3, 3, -1, -1, -1, -1, 8, 3);     // full replay after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream feeder for the mini CPU datapath: holds a small loadable instruction memory, sequences a program counter and issues decoded per-instruction control fields (alu_op, write_reg, read_reg1, read_reg2, reg_write).
- Output is a one-entry registered buffer with a valid/ready handshake toward the control/register-file stage.
- A program is loaded while idle, launched with start, and signals done after its last instruction is consumed.

Parameters:
- IMEM_DEPTH, 16, number of instruction words (power of two).
- ADDR_W, 4, PC/address width, log2(IMEM_DEPTH).
- INSTR_W, 8, instruction width; fixed field map below.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_en  input  1  write load_data into memory at load_addr (honoured only in IDLE).
- load_addr  input  ADDR_W  load address.
- load_data  input  INSTR_W  instruction word: [7:6] alu_op, [5:4] write_reg, [3:2] read_reg1, [1:0] read_reg2.
- start  input  1  launch program (honoured only in IDLE).
- prog_len  input  ADDR_W+1  number of instructions to issue, sampled with start; values above IMEM_DEPTH clamp to IMEM_DEPTH.
- instr_ready  input  1  downstream accepts the current instruction.
- instr_valid  output  1  output buffer holds an instruction.
- alu_op  output  2  decoded field [7:6].
- write_reg  output  2  decoded field [5:4].
- read_reg1  output  2  decoded field [3:2].
- read_reg2  output  2  decoded field [1:0].
- reg_write  output  1  instr_valid AND instr_ready (combinational); a write happens only on handshake.
- pc  output  ADDR_W  address of the next word to fetch.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse when the program completes.

Behaviour:
- Reset (reset=0, async): state=IDLE; pc=0; issued count=0; instr_valid=0; all field outputs 0; done=0; busy=0. Memory contents are not cleared.
- Memory: register array, written synchronously on load_en in IDLE; read combinationally at pc. load_en in any other state is ignored.
- IDLE:
  - start with clamped length L>0 -> RUN; pc=0; count=0; len reg=L.
  - start with L=0 -> DONE directly; no instr_valid is ever raised.
  - start and load_en in the same cycle: the load is performed and start is honoured.
- RUN: a fetch fires when (!instr_valid || instr_ready) and count<len.
  - Fetch: output regs <= mem[pc]; instr_valid=1; pc=pc+1 (wraps mod IMEM_DEPTH); count=count+1.
  - When the final fetch fires (count reaches len): -> DRAIN.
  - Sustained throughput is 1 instruction/cycle under continuous ready.
  - First instr_valid is 2 cycles after the cycle start is sampled.
- Handshake:
  - Outputs stay stable while instr_valid && !instr_ready.
  - If a handshake occurs and no fetch fires in that cycle, instr_valid drops next cycle.
- DRAIN: on instr_valid && instr_ready: instr_valid=0 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. pc holds its final value until the next start.
- start while busy: ignored.
- Reset asserted mid-run: immediate return to reset values; no done pulse; memory retained.

Test Plan:
- Load mem[0..2]=8'h1B, 8'h64, 8'hC0; prog_len=3; start; instr_ready=1 -> instr_valid high 3 consecutive cycles starting 2 cycles after start with (alu_op,write_reg,read_reg1,read_reg2) = (0,1,2,3), (1,2,1,0), (3,0,0,0); reg_write high on those same 3 cycles; done pulses one cycle after the last handshake; pc=3.
- Same program with instr_ready low for 4 cycles during the 2nd instruction -> fields hold 8'h64 values, pc stays 2, reg_write=0 in those cycles; sequence resumes with no loss or duplication.
- prog_len=0, start -> done pulse on the cycle after start; instr_valid never asserts; busy stays 0.
- While busy, load_en at addr 1 with 8'hFF and start=1 -> mem[1] is unchanged on a later run; the running program is unaffected.
- prog_len=20 with 16 loaded words -> exactly 16 instructions issued, pc wraps to 0, one done pulse.
- Drive reset=0 after the 2nd instruction handshake -> instr_valid=0, pc=0, busy=0 immediately, no done; a re-run after reset replays the full program from mem[0].
